// File: rtl/pending_encoder_32_to_5.sv
// Sequential 32-to-5 encoder: accumulates multi-hot requests into a pending
// register and hands out one index per handshake in round-robin order.
module pending_encoder_32_to_5 (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] set_mask,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_idx,
  output logic [31:0] pending,
  output logic        busy
);

  logic [31:0] pend_q, pend_d;
  logic        valid_q, valid_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  ptr_q, ptr_d;

  logic        sel_hit;
  logic [4:0]  sel;
  logic        found;
  logic        free;
  logic [31:0] load_oh;

  // Scan the 32 positions starting at ptr; 5-bit addition wraps the search.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!found && pend_q[ptr_q + 5'(i)]) begin
        sel   = ptr_q + 5'(i);
        found = 1'b1;
      end
    end
  end

  assign sel_hit = |pend_q;
  assign free    = !valid_q || out_ready;

  always_comb begin
    load_oh = '0;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (free) begin
      valid_d = sel_hit;
      if (sel_hit) begin
        load_oh = 32'd1 << sel;
        idx_d   = sel;
        ptr_d   = sel + 5'd1;
      end
    end
    // Set is applied after the load-clear so a colliding set stays pending.
    pend_d = (pend_q & ~load_oh) | (ena ? set_mask : '0);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign pending   = pend_q;
  assign busy      = valid_q || sel_hit;

endmodule

// File: tb/tb_pending_encoder_32_to_5.sv
// Bench for pending_encoder_32_to_5: directed scenarios plus random traffic
// compared every cycle against a behavioural round-robin model.
module tb_pending_encoder_32_to_5;

  logic        clk = 1'b0;
  logic        rst, ena, flush, out_ready;
  logic [31:0] set_mask;
  logic        out_valid, busy;
  logic [4:0]  out_idx;
  logic [31:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  bit m_pend [32];
  bit m_valid;
  int m_idx;
  int m_ptr;

  pending_encoder_32_to_5 dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .set_mask  (set_mask),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_pend_vec();
    logic [31:0] v;
    for (int b = 0; b < 32; b++) v[b] = m_pend[b];
    return v;
  endfunction

  function automatic bit model_any();
    for (int b = 0; b < 32; b++) if (m_pend[b]) return 1'b1;
    return 1'b0;
  endfunction

  // Apply inputs at the falling edge, advance the model by the spec rules,
  // then compare every output at the next falling edge.
  task automatic tick(input bit r, input bit e, input logic [31:0] m, input bit f, input bit rdy);
    int  pick;
    bit  is_free;
    rst = r; ena = e; set_mask = m; flush = f; out_ready = rdy;
    if (r || f) begin
      for (int b = 0; b < 32; b++) m_pend[b] = 1'b0;
      m_valid = 1'b0; m_idx = 0; m_ptr = 0;
    end else begin
      is_free = !m_valid || rdy;
      pick = -1;
      for (int k = 0; k < 32; k++) begin
        if (pick < 0 && m_pend[(m_ptr + k) % 32]) pick = (m_ptr + k) % 32;
      end
      if (is_free) begin
        if (pick >= 0) begin
          m_pend[pick] = 1'b0;
          m_valid = 1'b1;
          m_idx   = pick;
          m_ptr   = (pick + 1) % 32;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (e) for (int b = 0; b < 32; b++) if (m[b]) m_pend[b] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_idx",   32'(out_idx),   32'(m_idx));
    check_eq("pending",   pending,        model_pend_vec());
    check_eq("busy",      32'(busy),      32'(m_valid || model_any()));
  endtask

  task automatic idle(input bit rdy);
    tick(1'b0, 1'b0, '0, 1'b0, rdy);
  endtask

  task automatic set_bits(input logic [31:0] m, input bit rdy);
    tick(1'b0, 1'b1, m, 1'b0, rdy);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  logic [31:0] rmask;

  initial begin
    rst = 1'b0; ena = 1'b0; set_mask = '0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    // Reset values
    do_reset();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_idx", 32'(out_idx), 32'd0);
    check_eq("rst_pending", pending, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // Single request: two cycles from set to valid
    set_bits(32'h0000_0020, 1'b0);
    check_eq("single_not_yet", 32'(out_valid), 32'd0);
    idle(1'b0);
    check_eq("single_valid", 32'(out_valid), 32'd1);
    check_eq("single_idx", 32'(out_idx), 32'd5);
    check_eq("single_pend", pending, 32'd0);
    idle(1'b1);
    check_eq("single_drop", 32'(out_valid), 32'd0);

    // Round-robin wrap: ptr moved to 30, then 31,0,1 back to back
    do_reset();
    set_bits(32'h2000_0000, 1'b0);
    idle(1'b0);
    check_eq("wrap_first", 32'(out_idx), 32'd29);
    set_bits(32'h8000_0003, 1'b1);
    idle(1'b1);
    check_eq("wrap_a", 32'(out_idx), 32'd31);
    idle(1'b1);
    check_eq("wrap_b", 32'(out_idx), 32'd0);
    check_eq("wrap_b_v", 32'(out_valid), 32'd1);
    idle(1'b1);
    check_eq("wrap_c", 32'(out_idx), 32'd1);
    check_eq("wrap_c_v", 32'(out_valid), 32'd1);
    // ptr is now 2: bits 1 and 3 set -> 3 must come before 1
    set_bits(32'h0000_000A, 1'b1);
    idle(1'b1);
    check_eq("wrap_ptr2", 32'(out_idx), 32'd3);

    // Backpressure
    do_reset();
    set_bits(32'h0000_0104, 1'b0);
    idle(1'b0);
    for (int c = 0; c < 5; c++) begin
      idle(1'b0);
      check_eq("bp_idx", 32'(out_idx), 32'd2);
      check_eq("bp_pend", pending, 32'h0000_0100);
    end
    idle(1'b1);
    check_eq("bp_next", 32'(out_idx), 32'd8);
    check_eq("bp_next_v", 32'(out_valid), 32'd1);

    // Set/load collision
    do_reset();
    set_bits(32'h0000_0001, 1'b0);
    set_bits(32'h0000_0001, 1'b0);
    check_eq("coll_idx", 32'(out_idx), 32'd0);
    check_eq("coll_pend", pending, 32'h0000_0001);
    idle(1'b1);
    check_eq("coll_again", 32'(out_idx), 32'd0);
    check_eq("coll_again_v", 32'(out_valid), 32'd1);
    check_eq("coll_empty", pending, 32'd0);

    // Flush priority over a same-cycle set
    do_reset();
    set_bits(32'hFFFF_FFFF, 1'b0);
    idle(1'b0);
    set_bits(32'hFFFF_FFFF, 1'b0);
    check_eq("fl_pre_pend", pending, 32'hFFFF_FFFF);
    check_eq("fl_pre_v", 32'(out_valid), 32'd1);
    tick(1'b0, 1'b1, 32'h0000_000F, 1'b1, 1'b1);
    check_eq("fl_pend", pending, 32'd0);
    check_eq("fl_valid", 32'(out_valid), 32'd0);
    check_eq("fl_busy", 32'(busy), 32'd0);
    set_bits(32'h8000_0001, 1'b1);
    idle(1'b1);
    check_eq("fl_ptr0", 32'(out_idx), 32'd0);

    // Full drain
    do_reset();
    set_bits(32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 32; i++) begin
      idle(1'b1);
      check_eq("drain_idx", 32'(out_idx), 32'(i));
      check_eq("drain_v", 32'(out_valid), 32'd1);
    end
    idle(1'b1);
    check_eq("drain_end_v", 32'(out_valid), 32'd0);
    check_eq("drain_end_busy", 32'(busy), 32'd0);

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 9))
        0:       rmask = 32'd1 << $urandom_range(0, 31);
        1:       rmask = 32'hFFFF_FFFF;
        2, 3:    rmask = $urandom();
        default: rmask = $urandom() & $urandom() & $urandom();
      endcase
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, rmask,
           $urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pending_encoder_32_to_5.md
# pending_encoder_32_to_5

Sequential 32-to-5 encoder: accumulates a 32-bit multi-hot request vector into a pending register and emits one 5-bit index per handshake, round-robin. It is the reverse of the core's 5-to-32 one-hot decoders. It converts register-file write masks and scoreboard/interrupt bit-vectors back into register indices for sequential servicing, for example writeback replay or debug register dump.

## Interface
- No parameters; width fixed at 32 requests / 5-bit index.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- ena  input  1  when 1, set_mask is ORed into pending this cycle
- set_mask  input  32  request bits to set (multi-hot allowed)
- flush  input  1  synchronous clear of pending and output stage
- out_ready  input  1  consumer accepts out_idx this cycle
- out_valid  output  1  out_idx holds a valid index
- out_idx  output  5  encoded index of the offered request
- pending  output  32  current pending register (bits not yet loaded to output)
- busy  output  1  out_valid | (|pending)

## Operation
- State: pending[31:0], out_valid, out_idx[4:0], ptr[4:0] (round-robin start).
- Reset: pending=0, out_valid=0, out_idx=0, ptr=0, busy=0.
- Output stage "free" when !out_valid or (out_valid & out_ready).
- Selection (combinational from registered pending): first set bit scanning ptr, ptr+1, …, 31, 0, …, ptr-1 (mod 32). sel_hit = |pending.
- Load: if free and sel_hit, then at the edge out_valid←1, out_idx←sel, ptr←sel+1 (5-bit wrap: 31→0), and pending[sel] is cleared.
- If free and !sel_hit, then out_valid←0 at the edge. out_idx holds its old value (don't-care).
- While out_valid & !out_ready: out_idx, out_valid, and ptr hold stable. Pending still accumulates sets.
- Pending update: pending_next = (pending & ~load_onehot) | (ena ? set_mask : 0).
  - Set wins over the load-clear: the same bit loaded and set in one cycle stays pending and is re-reported later.
  - A set to the index currently in the output stage re-pends it; no merge.
- out_ready while !out_valid is ignored.
- Priority: rst > flush > normal.
  - flush: pending←0, out_valid←0, ptr←0. set_mask in the same cycle is discarded.
- Arithmetic: ptr and sel are 5-bit unsigned, wrap mod 32. Search covers exactly 32 positions; no bit is skipped or scanned twice.

## Timing
- Latency: ena/set_mask at edge N → pending bit visible after N. If the output stage is free, out_valid=1 after edge N+1 (2 cycles set→valid).
- Throughput: one index per cycle with out_ready held high and pending non-empty. No bubble between back-to-back indices.
- Drain: k pending bits with continuous out_ready produce k consecutive valid cycles in round-robin order.
- Mid-operation reset/flush: all outputs reach their reset values on the next edge. A transfer offered in the same cycle is dropped and does not count as accepted.
- No combinational path from out_ready or set_mask to any output; all outputs are registered.

## Test plan
- Reset then single request: ena=1, set_mask=0x0000_0020 at cycle 0 → out_valid=1, out_idx=5 after edge 2; pending=0. out_ready=1 → out_valid=0 next cycle.
- Round-robin wrap: ptr advanced to 30 (serve idx 29 first), then set_mask=0x8000_0003 → outputs 31, 0, 1 in consecutive cycles with out_ready=1; ptr ends at 2.
- Backpressure: pending=0x0000_0104, out_ready=0 for 5 cycles → out_idx=2 held stable, pending=0x0000_0100. Then out_ready=1 → 8 follows with no bubble.
- Set/load collision: pending=0x1, output free, ena=1 with set_mask=0x1 in the same cycle → out_idx=0 loaded, pending stays 0x1. Index 0 is reported twice in total.
- Flush priority: pending=0xFFFF_FFFF, out_valid=1, flush=1 with ena=1 set_mask=0xF → next cycle pending=0, out_valid=0, busy=0, ptr=0.
- Full drain: set_mask=0xFFFF_FFFF once, out_ready=1 → indices 0..31 in order over 32 consecutive cycles, then out_valid=0 and busy=0.
